spike_event_encoder: RTL and testbench

Sequential spike-extraction stage that sits downstream of the leaky-integrate voltage update. It accepts one updated membrane-voltage vector per transaction, scans the active lanes in order, and emits one event per lane whose voltage reaches the threshold. Each spiking lane's voltage is reset to zero in the returned vector. The spike mask and post-reset vector are returned for write-back to the voltage register file.

---
 rtl/spike_event_encoder.sv | 139 +++++++++++++
 tb/tb_spike_event_encoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/spike_event_encoder.sv
// Sequential spike extractor: scans the active lanes of an updated voltage vector,
// emits one handshaked event per lane at or above threshold, and zeroes those lanes.
module spike_event_encoder #(
   parameter int unsigned LANES = 16,
   parameter int unsigned XLEN  = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*XLEN-1:0]     vol_in,
   input  logic [XLEN-1:0]           vt,
   input  logic [1:0]                VL,
   output logic                      ev_valid,
   input  logic                      ev_ready,
   output logic [$clog2(LANES)-1:0]  ev_lane,
   output logic [XLEN-1:0]           ev_vol,
   output logic [LANES*XLEN-1:0]     vol_out,
   output logic [LANES-1:0]          spike_mask,
   output logic                      done,
   output logic                      busy
);

   localparam int unsigned IDXW = $clog2(LANES);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SCAN = 2'b01,
      EMIT = 2'b10,
      DONE = 2'b11
   } state_t;

   state_t                      state;
   state_t                      state_next;
   logic [LANES-1:0][XLEN-1:0]  vol_q;
   logic [XLEN-1:0]             vt_q;
   logic [IDXW-1:0]             idx;
   logic [IDXW-1:0]             last_idx;
   logic [IDXW-1:0]             last_c;
   logic                        hit_c;
   logic                        at_last_c;
   logic                        accept_c;
   logic                        take_c;
   logic                        step_c;

   assign vol_out   = vol_q;
   assign hit_c     = (vol_q[idx] >= vt_q);
   assign at_last_c = (idx == last_idx);

   // Vector length code to index of the last active lane.
   always_comb begin
      last_c = '0;
      case (VL)
         2'b01:   last_c = IDXW'(3);
         2'b10:   last_c = IDXW'(LANES - 1);
         default: last_c = '0;
      endcase
   end

   // Next-state and datapath strobes.
   always_comb begin
      state_next = state;
      accept_c   = 1'b0;
      take_c     = 1'b0;
      step_c     = 1'b0;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               accept_c   = 1'b1;
               state_next = SCAN;
            end
         end
         SCAN: begin
            if (hit_c) begin
               take_c     = 1'b1;
               state_next = EMIT;
            end else if (at_last_c) begin
               state_next = DONE;
            end else begin
               step_c = 1'b1;
            end
         end
         EMIT: begin
            if (ev_ready) begin
               if (at_last_c) begin
                  state_next = DONE;
               end else begin
                  step_c     = 1'b1;
                  state_next = SCAN;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State, status flags and working vector; flags are decoded from the next state
   // so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         busy       <= 1'b0;
         ev_valid   <= 1'b0;
         done       <= 1'b0;
         ev_lane    <= '0;
         ev_vol     <= '0;
         vol_q      <= '0;
         vt_q       <= '0;
         spike_mask <= '0;
         idx        <= '0;
         last_idx   <= '0;
      end else begin
         state    <= state_next;
         in_ready <= (state_next == IDLE);
         busy     <= (state_next != IDLE);
         ev_valid <= (state_next == EMIT);
         done     <= (state_next == DONE);
         if (accept_c) begin
            vol_q      <= vol_in;
            vt_q       <= vt;
            last_idx   <= last_c;
            idx        <= '0;
            spike_mask <= '0;
         end
         if (take_c) begin
            ev_lane           <= idx;
            ev_vol            <= vol_q[idx];
            vol_q[idx]        <= '0;
            spike_mask[idx]   <= 1'b1;
         end
         if (step_c) begin
            idx <= idx + IDXW'(1);
         end
      end
   end

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed bench for spike_event_encoder: event order, latency, stalls, masking and reset abort.
module tb_spike_event_encoder;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [511:0] vol_in;
   logic [31:0]  vt;
   logic [1:0]   VL;
   logic         ev_valid;
   logic         ev_ready;
   logic [3:0]   ev_lane;
   logic [31:0]  ev_vol;
   logic [511:0] vol_out;
   logic [15:0]  spike_mask;
   logic         done;
   logic         busy;

   int checks = 0;
   int passes = 0;

   logic [15:0][31:0] vin;
   logic [15:0][31:0] vexp;
   logic [3:0]        ev_l[$];
   logic [31:0]       ev_v[$];
   int                dcyc;

   spike_event_encoder dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .vol_in(vol_in), .vt(vt), .VL(VL), .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_lane(ev_lane), .ev_vol(ev_vol), .vol_out(vol_out), .spike_mask(spike_mask),
      .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
   endtask

   // Accept one vector, then run to the done pulse; stall holds ev_ready low on the first event.
   task automatic run(input logic [1:0] vl, input logic [31:0] t, input int stall, output int dc);
      bit          holding;
      logic [3:0]  hl;
      logic [31:0] hv;
      holding = 0; hl = '0; hv = '0;
      ev_l.delete(); ev_v.delete();
      dc = -1;
      chk("in_ready_idle", 512'(in_ready), 512'(1));
      vol_in = vin; vt = t; VL = vl; in_valid = 1'b1; ev_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      vt = 32'hFFFF_FFFF; VL = 2'b10; vol_in = '1;
      chk("busy_after_accept", 512'(busy), 512'(1));
      for (int k = 1; k <= 200; k++) begin
         if (done) begin
            dc = k;
            break;
         end
         in_valid = 1'b0;
         if (ev_valid) begin
            if (holding) begin
               chk("ev_lane_stable", 512'(ev_lane), 512'(hl));
               chk("ev_vol_stable", 512'(ev_vol), 512'(hv));
            end
            if (stall > 0) begin
               if (!holding) begin
                  holding = 1; hl = ev_lane; hv = ev_vol;
               end
               ev_ready = 1'b0;
               if (stall == 3) begin
                  in_valid = 1'b1;
                  chk("in_ready_busy", 512'(in_ready), 512'(0));
               end
               stall--;
            end else begin
               holding  = 0;
               ev_ready = 1'b1;
               ev_l.push_back(ev_lane);
               ev_v.push_back(ev_vol);
            end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; ev_ready = 1'b1;
      if (dc < 0) chk("done_timeout", 512'(0), 512'(1));
      @(posedge clk); #1;
      chk("done_single_pulse", 512'(done), 512'(0));
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; vol_in = '0; vt = '0; VL = '0; ev_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 512'(in_ready), 512'(1));
      chk("rst_quiet", {ev_valid, done, busy, ev_lane, ev_vol, spike_mask}, '0);
      chk("rst_vol_out", vol_out, '0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // 16 lanes, nobody reaches threshold
      for (int i = 0; i < 16; i++) vin[i] = 32'd50;
      run(2'b10, 32'd100, 0, dcyc);
      chk("t1_done_cycle", 512'(dcyc), 512'(17));
      chk("t1_events", 512'(ev_l.size()), 512'(0));
      chk("t1_mask", 512'(spike_mask), 512'(0));
      chk("t1_vol_out", vol_out, vin);

      // lanes 3 and 15 exactly at threshold
      for (int i = 0; i < 16; i++) vin[i] = 32'd99;
      vin[3] = 32'd100; vin[15] = 32'd100;
      vexp = vin; vexp[3] = '0; vexp[15] = '0;
      run(2'b10, 32'd100, 0, dcyc);
      chk("t2_done_cycle", 512'(dcyc), 512'(19));
      chk("t2_events", 512'(ev_l.size()), 512'(2));
      if (ev_l.size() == 2) begin
         chk("t2_ev0", {ev_l[0], ev_v[0]}, {4'd3, 32'd100});
         chk("t2_ev1", {ev_l[1], ev_v[1]}, {4'd15, 32'd100});
      end
      chk("t2_mask", 512'(spike_mask), 512'(16'h8008));
      chk("t2_vol_out", vol_out, vexp);

      // 4 lanes, zero threshold
      for (int i = 0; i < 16; i++) vin[i] = (i < 4) ? 32'd7 : 32'hFFFF_FFFF;
      vexp = vin; for (int i = 0; i < 4; i++) vexp[i] = '0;
      run(2'b01, 32'd0, 0, dcyc);
      chk("t3_done_cycle", 512'(dcyc), 512'(9));
      chk("t3_events", 512'(ev_l.size()), 512'(4));
      for (int i = 0; i < ev_l.size() && i < 4; i++)
         chk("t3_ev", {ev_l[i], ev_v[i]}, {4'(i), 32'd7});
      chk("t3_mask", 512'(spike_mask), 512'(16'h000F));
      chk("t3_vol_out", vol_out, vexp);

      // VL=11 is one lane; unsigned compare
      vin = '0; vin[0] = 32'hFFFF_FFFF; vin[1] = 32'd20;
      vexp = vin; vexp[0] = '0;
      run(2'b11, 32'd10, 0, dcyc);
      chk("t4_done_cycle", 512'(dcyc), 512'(3));
      chk("t4_events", 512'(ev_l.size()), 512'(1));
      if (ev_l.size() == 1) chk("t4_ev0", {ev_l[0], ev_v[0]}, {4'd0, 32'hFFFF_FFFF});
      chk("t4_mask", 512'(spike_mask), 512'(16'h0001));
      chk("t4_vol_out", vol_out, vexp);

      // five stall cycles on the first event, in_valid poked while busy
      for (int i = 0; i < 16; i++) vin[i] = 32'd99;
      vin[3] = 32'd100; vin[15] = 32'd100;
      vexp = vin; vexp[3] = '0; vexp[15] = '0;
      run(2'b10, 32'd100, 5, dcyc);
      chk("t5_done_cycle", 512'(dcyc), 512'(24));
      chk("t5_events", 512'(ev_l.size()), 512'(2));
      if (ev_l.size() == 2) chk("t5_ev0", {ev_l[0], ev_v[0]}, {4'd3, 32'd100});
      chk("t5_mask", 512'(spike_mask), 512'(16'h8008));
      chk("t5_vol_out", vol_out, vexp);

      // reset while an event is pending
      vol_in = vin; vt = 32'd100; VL = 2'b10; in_valid = 1'b1; ev_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 40 && !ev_valid; k++) begin
         @(posedge clk); #1;
      end
      chk("t6_reached_emit", 512'(ev_valid), 512'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("t6_ev_valid_drop", 512'(ev_valid), 512'(0));
      chk("t6_in_ready", 512'(in_ready), 512'(1));
      chk("t6_quiet", {done, busy, ev_lane, ev_vol, spike_mask}, '0);
      chk("t6_vol_out", vol_out, '0);
      ev_ready = 1'b1;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("t6_no_done", 512'(done), 512'(0));
      vin = '0; vin[0] = 32'hFFFF_FFFF; vin[1] = 32'd20;
      vexp = vin; vexp[0] = '0;
      run(2'b11, 32'd10, 0, dcyc);
      chk("t6_fresh_done", 512'(dcyc), 512'(3));
      chk("t6_fresh_mask", 512'(spike_mask), 512'(16'h0001));
      chk("t6_fresh_vol_out", vol_out, vexp);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
